// File: rtl/rcu_pll_seq.sv
// ============================================================================
// rcu_pll_seq : PLL reprogramming and glitch-free core clock switch sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

`ifndef RCU_CLK_CFG_WIDTH
`define RCU_CLK_CFG_WIDTH 8
`endif

module rcu_pll_seq #(
  parameter int CFG_WIDTH        = `RCU_CLK_CFG_WIDTH,
  parameter int GATE_CYCLES      = 4,
  parameter int LOCK_WAIT_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES   = 65536
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [CFG_WIDTH-1:0] cfg_i,
  input  logic                 pll_en_i,
  input  logic                 pll_lock_i,
  output logic                 pll_en_o,
  output logic [CFG_WIDTH-1:0] pll_cfg_o,
  output logic                 clk_sel_o,
  output logic                 core_gate_o,
  output logic                 busy_o,
  output logic                 pllstrb_o,
  output logic                 err_tmo_o,
  output logic                 err_lol_o,
  input  logic                 err_clr_i
);

  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GATE_W = $clog2(GATE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LOCK_N    = CNT_W'(LOCK_WAIT_CYCLES);
  localparam logic [CNT_W-1:0]  TMO_N     = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_SWAP = 3'd2,
    S_POST = 3'd3,
    S_PDN  = 3'd4,
    S_WAIT = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic                  tgt_sel_q, tgt_sel_d;
  logic                  lol_seq_q, lol_seq_d;
  logic                  lol_pend_q, lol_pend_d;
  logic [CFG_WIDTH-1:0]  cfg_lat_q, cfg_lat_d;
  logic                  en_lat_q, en_lat_d;
  logic [GATE_W-1:0]     gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]      stable_q, stable_d, stable_nxt;
  logic [CNT_W-1:0]      total_q, total_d, total_nxt;
  logic                  pll_en_q, pll_en_d;
  logic [CFG_WIDTH-1:0]  pll_cfg_q, pll_cfg_d;
  logic                  clk_sel_q, clk_sel_d;
  logic                  gate_q, gate_d;
  logic                  err_tmo_q, err_tmo_d, err_tmo_set;
  logic                  err_lol_q, err_lol_d, err_lol_set;
  logic                  lol_now;

  // A lock drop seen during a swap onto the PLL is remembered until IDLE handles it.
  assign lol_now     = clk_sel_q & (~pll_lock_i | lol_pend_q);
  assign cfg_ready_o = (state_q == S_IDLE) & ~lol_now;
  assign busy_o      = ~cfg_ready_o;
  assign pllstrb_o   = clk_sel_q & pll_lock_i;
  assign pll_en_o    = pll_en_q;
  assign pll_cfg_o   = pll_cfg_q;
  assign clk_sel_o   = clk_sel_q;
  assign core_gate_o = gate_q;
  assign err_tmo_o   = err_tmo_q;
  assign err_lol_o   = err_lol_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      tgt_sel_q  <= 1'b0;
      lol_seq_q  <= 1'b0;
      lol_pend_q <= 1'b0;
      cfg_lat_q  <= '0;
      en_lat_q   <= 1'b0;
      gate_cnt_q <= '0;
      stable_q   <= '0;
      total_q    <= '0;
      pll_en_q   <= 1'b0;
      pll_cfg_q  <= '0;
      clk_sel_q  <= 1'b0;
      gate_q     <= 1'b1;
      err_tmo_q  <= 1'b0;
      err_lol_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_sel_q  <= tgt_sel_d;
      lol_seq_q  <= lol_seq_d;
      lol_pend_q <= lol_pend_d;
      cfg_lat_q  <= cfg_lat_d;
      en_lat_q   <= en_lat_d;
      gate_cnt_q <= gate_cnt_d;
      stable_q   <= stable_d;
      total_q    <= total_d;
      pll_en_q   <= pll_en_d;
      pll_cfg_q  <= pll_cfg_d;
      clk_sel_q  <= clk_sel_d;
      gate_q     <= gate_d;
      err_tmo_q  <= err_tmo_d;
      err_lol_q  <= err_lol_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tgt_sel_d   = tgt_sel_q;
    lol_seq_d   = lol_seq_q;
    lol_pend_d  = lol_pend_q;
    cfg_lat_d   = cfg_lat_q;
    en_lat_d    = en_lat_q;
    gate_cnt_d  = gate_cnt_q;
    stable_d    = stable_q;
    total_d     = total_q;
    pll_en_d    = pll_en_q;
    pll_cfg_d   = pll_cfg_q;
    clk_sel_d   = clk_sel_q;
    err_tmo_set = 1'b0;
    err_lol_set = 1'b0;

    stable_nxt = pll_lock_i ? ((stable_q == '1) ? stable_q : stable_q + CNT_W'(1)) : '0;
    total_nxt  = (total_q == '1) ? total_q : total_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (lol_now) begin
          err_lol_set = 1'b1;
          lol_pend_d  = 1'b0;
          lol_seq_d   = 1'b1;
          tgt_sel_d   = 1'b0;
          gate_cnt_d  = '0;
          state_d     = S_PRE;
        end else if (cfg_valid_i) begin
          cfg_lat_d  = cfg_i;
          en_lat_d   = pll_en_i;
          lol_seq_d  = 1'b0;
          gate_cnt_d = '0;
          if (clk_sel_q) begin
            tgt_sel_d = 1'b0;
            state_d   = S_PRE;
          end else begin
            pll_en_d  = 1'b0;
            pll_cfg_d = cfg_i;
            state_d   = S_PDN;
          end
        end
      end
      S_PRE: begin
        if (gate_cnt_q == GATE_LAST) begin
          gate_cnt_d = '0;
          state_d    = S_SWAP;
        end else begin
          gate_cnt_d = gate_cnt_q + GATE_W'(1);
        end
      end
      S_SWAP: begin
        clk_sel_d = tgt_sel_q;
        state_d   = S_POST;
      end
      S_POST: begin
        if (gate_cnt_q == GATE_LAST) begin
          gate_cnt_d = '0;
          if (tgt_sel_q) begin
            state_d = S_IDLE;
          end else if (lol_seq_q) begin
            pll_en_d  = 1'b0;
            lol_seq_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            // Config is loaded on the same edge the PLL is disabled.
            pll_en_d  = 1'b0;
            pll_cfg_d = cfg_lat_q;
            state_d   = S_PDN;
          end
        end else begin
          gate_cnt_d = gate_cnt_q + GATE_W'(1);
        end
      end
      S_PDN: begin
        if (en_lat_q) begin
          pll_en_d = 1'b1;
          stable_d = '0;
          total_d  = '0;
          state_d  = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        stable_d = stable_nxt;
        total_d  = total_nxt;
        if (stable_nxt == LOCK_N) begin
          tgt_sel_d  = 1'b1;
          lol_pend_d = 1'b0;
          gate_cnt_d = '0;
          state_d    = S_PRE;
        end else if (total_nxt == TMO_N) begin
          pll_en_d    = 1'b0;
          err_tmo_set = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q inside {S_PRE, S_SWAP, S_POST}) && tgt_sel_q && !pll_lock_i)
      lol_pend_d = 1'b1;

    gate_d    = !(state_d inside {S_PRE, S_SWAP, S_POST});
    err_tmo_d = err_tmo_set | (err_tmo_q & ~err_clr_i);
    err_lol_d = err_lol_set | (err_lol_q & ~err_clr_i);
  end

endmodule

`default_nettype wire

// File: tb/tb_rcu_pll_seq.sv
// ============================================================================
// tb_rcu_pll_seq : scenario bench for rcu_pll_seq with a lock-window predictor
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_rcu_pll_seq;

  localparam int CW = 3;
  localparam int G  = 2;
  localparam int L  = 8;
  localparam int T  = 64;
  localparam int GATED = 2 * G + 1;

  logic          clk = 1'b0;
  logic          rst, cfg_valid, pll_en_in, pll_lock, err_clr;
  logic [CW-1:0] cfg;
  logic          ready, pll_en, clk_sel, gate, busy, pllstrb, err_tmo, err_lol;
  logic [CW-1:0] pll_cfg;

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;
  bit lk [1:T];
  logic [CW-1:0] cur_cfg;

  rcu_pll_seq #(
    .CFG_WIDTH(CW), .GATE_CYCLES(G), .LOCK_WAIT_CYCLES(L), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(ready),
    .cfg_i(cfg), .pll_en_i(pll_en_in), .pll_lock_i(pll_lock), .pll_en_o(pll_en),
    .pll_cfg_o(pll_cfg), .clk_sel_o(clk_sel), .core_gate_o(gate), .busy_o(busy),
    .pllstrb_o(pllstrb), .err_tmo_o(err_tmo), .err_lol_o(err_lol), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  // Cycle-wide invariants: gate windows, mux and config stability, status decode.
  logic          prev_sel, prev_gate;
  logic [CW-1:0] prev_cfg;
  int            low_run = 0;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      vectors++; if (pllstrb !== (clk_sel & pll_lock)) begin miscompares++; $display("FAIL mon_pllstrb: got %b expected %b", pllstrb, clk_sel & pll_lock); end
      vectors++; if (busy !== ~ready) begin miscompares++; $display("FAIL mon_busy: got %b expected %b", busy, ~ready); end
      if (clk_sel !== prev_sel) begin
        vectors++; if (gate !== 1'b0 || prev_gate !== 1'b0) begin miscompares++; $display("FAIL mon_sel_while_gated: gate now %b before %b, required 0/0", gate, prev_gate); end
      end
      if (pll_cfg !== prev_cfg) begin
        vectors++; if (pll_en !== 1'b0) begin miscompares++; $display("FAIL mon_cfg_while_en: pll_en %b required 0", pll_en); end
      end
      if (gate === 1'b0) low_run++;
      else if (prev_gate === 1'b0) begin
        vectors++; if (low_run != GATED) begin miscompares++; $display("FAIL mon_gate_window: got %0d expected %0d", low_run, GATED); end
        low_run = 0;
      end
    end else begin
      low_run = 0;
    end
    prev_sel  = clk_sel;
    prev_gate = gate;
    prev_cfg  = pll_cfg;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // First WAIT_LOCK cycle completing L consecutive locked cycles, 0 if none within T.
  function automatic int predict_lock();
    int run = 0;
    for (int j = 1; j <= T; j++) begin
      run = lk[j] ? run + 1 : 0;
      if (run == L) return j;
    end
    return 0;
  endfunction

  task automatic test_reset();
    vectors++; if (pll_en !== 1'b0 || pll_cfg !== '0) begin miscompares++; $display("FAIL reset_pll: en %b cfg %0d required 0/0", pll_en, pll_cfg); end
    vectors++; if (clk_sel !== 1'b0 || gate !== 1'b1) begin miscompares++; $display("FAIL reset_mux: sel %b gate %b required 0/1", clk_sel, gate); end
    vectors++; if (ready !== 1'b1 || err_tmo !== 1'b0 || err_lol !== 1'b0) begin miscompares++; $display("FAIL reset_status: ready %b tmo %b lol %b required 1/0/0", ready, err_tmo, err_lol); end
    cur_cfg = '0;
  endtask

  // Enable request from bypass, lock pattern taken from lk[].
  task automatic test_enable(input logic [CW-1:0] c, output bit locked);
    int jl, n, k;
    pll_lock = 1'b0; cfg = c; pll_en_in = 1'b1; cfg_valid = 1'b1; #1;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL en_ready: got %b expected 1", ready); end
    tick(); cfg_valid = 1'b0;
    cur_cfg = c;
    vectors++; if (pll_en !== 1'b0 || pll_cfg !== c) begin miscompares++; $display("FAIL en_pdn: en %b cfg %0d required 0/%0d", pll_en, pll_cfg, c); end
    tick();
    vectors++; if (pll_en !== 1'b1 || clk_sel !== 1'b0 || gate !== 1'b1) begin miscompares++; $display("FAIL en_wait: en %b sel %b gate %b required 1/0/1", pll_en, clk_sel, gate); end
    jl = predict_lock();
    locked = (jl != 0);
    n = locked ? jl : T;
    for (int j = 1; j <= n; j++) begin
      pll_lock = lk[j];
      if (j == n) begin
        vectors++; if (pll_en !== 1'b1) begin miscompares++; $display("FAIL en_held: got %b expected 1 at cycle %0d", pll_en, j); end
      end
      tick();
    end
    if (locked) begin
      pll_lock = 1'b1;
      k = 0;
      while (clk_sel !== 1'b1 && k < 10) begin tick(); k++; end
      vectors++; if (k != G + 1) begin miscompares++; $display("FAIL en_switch_latency: got %0d expected %0d", k, G + 1); end
      repeat (G) tick();
      vectors++; if (gate !== 1'b1 || ready !== 1'b1 || pllstrb !== 1'b1) begin miscompares++; $display("FAIL en_on_pll: gate %b ready %b strb %b required 1/1/1", gate, ready, pllstrb); end
      vectors++; if (err_tmo !== 1'b0 || pll_cfg !== c) begin miscompares++; $display("FAIL en_final: tmo %b cfg %0d required 0/%0d", err_tmo, pll_cfg, c); end
    end else begin
      vectors++; if (pll_en !== 1'b0 || err_tmo !== 1'b1 || clk_sel !== 1'b0) begin miscompares++; $display("FAIL tmo_abort: en %b tmo %b sel %b required 0/1/0", pll_en, err_tmo, clk_sel); end
      vectors++; if (gate !== 1'b1 || ready !== 1'b1) begin miscompares++; $display("FAIL tmo_idle: gate %b ready %b required 1/1", gate, ready); end
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      vectors++; if (err_tmo !== 1'b0) begin miscompares++; $display("FAIL tmo_clear: got %b expected 0", err_tmo); end
    end
  endtask

  task automatic test_to_bypass(input logic [CW-1:0] c);
    int k;
    cfg = c; pll_en_in = 1'b0; cfg_valid = 1'b1; #1;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL byp_ready: got %b expected 1", ready); end
    tick(); cfg_valid = 1'b0;
    vectors++; if (gate !== 1'b0 || clk_sel !== 1'b1 || pll_en !== 1'b1) begin miscompares++; $display("FAIL byp_pre: gate %b sel %b en %b required 0/1/1", gate, clk_sel, pll_en); end
    k = 0;
    while (clk_sel !== 1'b0 && k < 10) begin tick(); k++; end
    vectors++; if (k != G + 1) begin miscompares++; $display("FAIL byp_switch_latency: got %0d expected %0d", k, G + 1); end
    repeat (G) tick();
    cur_cfg = c;
    vectors++; if (pll_en !== 1'b0 || pll_cfg !== c || gate !== 1'b1) begin miscompares++; $display("FAIL byp_pdn: en %b cfg %0d gate %b required 0/%0d/1", pll_en, pll_cfg, gate, c); end
    tick();
    vectors++; if (ready !== 1'b1 || pll_en !== 1'b0 || pllstrb !== 1'b0) begin miscompares++; $display("FAIL byp_idle: ready %b en %b strb %b required 1/0/0", ready, pll_en, pllstrb); end
    pll_lock = 1'b0;
  endtask

  task automatic test_lock_delay();
    bit ok;
    for (int j = 1; j <= T; j++) lk[j] = (j > 10);
    test_enable(3'd5, ok);
  endtask

  task automatic test_lock_glitch();
    bit ok;
    for (int j = 1; j <= T; j++) lk[j] = (j != 6);
    test_enable(3'($urandom), ok);
  endtask

  task automatic test_timeout();
    bit ok;
    for (int j = 1; j <= T; j++) lk[j] = 1'b0;
    test_enable(3'($urandom), ok);
  endtask

  task automatic test_lol();
    int k;
    pll_lock = 1'b0; cfg = ~cur_cfg; pll_en_in = 1'b1; cfg_valid = 1'b1; #1;
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL lol_ready: got %b expected 0", ready); end
    tick(); cfg_valid = 1'b0;
    vectors++; if (err_lol !== 1'b1 || gate !== 1'b0) begin miscompares++; $display("FAIL lol_detect: lol %b gate %b required 1/0", err_lol, gate); end
    k = 0;
    while (clk_sel !== 1'b0 && k < 10) begin tick(); k++; end
    vectors++; if (k != G + 1) begin miscompares++; $display("FAIL lol_switch_latency: got %0d expected %0d", k, G + 1); end
    repeat (G) tick();
    vectors++; if (pll_en !== 1'b0 || gate !== 1'b1 || ready !== 1'b1) begin miscompares++; $display("FAIL lol_idle: en %b gate %b ready %b required 0/1/1", pll_en, gate, ready); end
    vectors++; if (pll_cfg !== cur_cfg) begin miscompares++; $display("FAIL lol_cfg_kept: got %0d expected %0d", pll_cfg, cur_cfg); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    vectors++; if (err_lol !== 1'b0) begin miscompares++; $display("FAIL lol_clear: got %b expected 0", err_lol); end
  endtask

  task automatic test_lol_in_swap();
    int k;
    logic [CW-1:0] c;
    c = 3'($urandom);
    pll_lock = 1'b0; cfg = c; pll_en_in = 1'b1; cfg_valid = 1'b1;
    tick(); cfg_valid = 1'b0; tick();
    cur_cfg = c;
    for (int j = 1; j <= L; j++) begin pll_lock = 1'b1; tick(); end
    pll_lock = 1'b0; tick(); pll_lock = 1'b1;
    k = 1;
    while (clk_sel !== 1'b1 && k < 10) begin tick(); k++; end
    vectors++; if (k != G + 1) begin miscompares++; $display("FAIL swp_complete_latency: got %0d expected %0d", k, G + 1); end
    repeat (G) tick();
    vectors++; if (gate !== 1'b1 || ready !== 1'b0 || err_lol !== 1'b0) begin miscompares++; $display("FAIL swp_pending: gate %b ready %b lol %b required 1/0/0", gate, ready, err_lol); end
    tick();
    vectors++; if (err_lol !== 1'b1 || gate !== 1'b0) begin miscompares++; $display("FAIL swp_lol: lol %b gate %b required 1/0", err_lol, gate); end
    k = 0;
    while (clk_sel !== 1'b0 && k < 10) begin tick(); k++; end
    repeat (G) tick();
    vectors++; if (pll_en !== 1'b0 || clk_sel !== 1'b0 || ready !== 1'b1) begin miscompares++; $display("FAIL swp_back: en %b sel %b ready %b required 0/0/1", pll_en, clk_sel, ready); end
    err_clr = 1'b1; tick(); err_clr = 1'b0; pll_lock = 1'b0;
  endtask

  task automatic test_rerequest();
    int k;
    bit ok;
    logic [CW-1:0] c;
    c = 3'($urandom);
    for (int j = 1; j <= T; j++) lk[j] = 1'b1;
    test_enable(c, ok);
    cfg = c; pll_en_in = 1'b1; cfg_valid = 1'b1;
    tick(); cfg_valid = 1'b0;
    vectors++; if (gate !== 1'b0 || ready !== 1'b0) begin miscompares++; $display("FAIL rr_start: gate %b ready %b required 0/0", gate, ready); end
    k = 0;
    while (clk_sel !== 1'b0 && k < 10) begin tick(); k++; end
    repeat (G) tick();
    vectors++; if (pll_en !== 1'b0 || pll_cfg !== c) begin miscompares++; $display("FAIL rr_pdn: en %b cfg %0d required 0/%0d", pll_en, pll_cfg, c); end
    tick();
    vectors++; if (pll_en !== 1'b1 || clk_sel !== 1'b0) begin miscompares++; $display("FAIL rr_wait: en %b sel %b required 1/0", pll_en, clk_sel); end
    cfg = ~c; pll_en_in = 1'b0; cfg_valid = 1'b1; #1;
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL rr_busy_ready: got %b expected 0", ready); end
    tick(); cfg_valid = 1'b0;
    k = 1;
    while (gate !== 1'b0 && k < 20) begin tick(); k++; end
    vectors++; if (k != L) begin miscompares++; $display("FAIL rr_lock_cycles: got %0d expected %0d", k, L); end
    k = 0;
    while (clk_sel !== 1'b1 && k < 10) begin tick(); k++; end
    repeat (G) tick();
    vectors++; if (pll_cfg !== c || ready !== 1'b1 || pllstrb !== 1'b1) begin miscompares++; $display("FAIL rr_final: cfg %0d ready %b strb %b required %0d/1/1", pll_cfg, ready, pllstrb, c); end
    test_to_bypass(3'($urandom));
  endtask

  task automatic test_reset_mid();
    cfg = 3'($urandom) | 3'd1; pll_en_in = 1'b1; pll_lock = 1'b0; cfg_valid = 1'b1;
    tick(); cfg_valid = 1'b0;
    repeat (4) tick();
    vectors++; if (pll_en !== 1'b1) begin miscompares++; $display("FAIL rm_in_wait: got %b expected 1", pll_en); end
    rst = 1'b1;
    tick();
    vectors++; if (pll_en !== 1'b0 || pll_cfg !== '0) begin miscompares++; $display("FAIL rm_during: en %b cfg %0d required 0/0", pll_en, pll_cfg); end
    tick(); tick();
    rst = 1'b0;
    tick();
    cur_cfg = '0;
    vectors++; if (pll_en !== 1'b0 || clk_sel !== 1'b0 || gate !== 1'b1 || ready !== 1'b1) begin miscompares++; $display("FAIL rm_after: en %b sel %b gate %b ready %b required 0/0/1/1", pll_en, clk_sel, gate, ready); end
  endtask

  task automatic test_random();
    bit ok;
    int dens;
    for (int it = 0; it < 8; it++) begin
      dens = $urandom_range(1, 8);
      for (int j = 1; j <= T; j++) lk[j] = ($urandom_range(0, dens) != 0);
      test_enable(3'($urandom), ok);
      if (ok) test_to_bypass(3'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; pll_en_in = 1'b0; pll_lock = 1'b0; err_clr = 1'b0; cfg = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    mon_en = 1'b1;
    test_reset();
    test_lock_delay();
    test_to_bypass(3'd2);
    test_lock_glitch();
    test_lol();
    test_timeout();
    test_lol_in_swap();
    test_rerequest();
    test_reset_mid();
    test_random();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
